// File: rtl/lcd_power_seq.sv
// Power sequencer for the TFT panel path: orders STBY release, timing-generator
// run, unblank and backlight on the way up, and the reverse on the way down.
module lcd_power_seq #(
  parameter int T_PWR    = 6750,
  parameter int T_OFF    = 6750,
  parameter int N_SYNC   = 4,
  parameter int N_BL     = 2,
  parameter int N_DOWN   = 2,
  parameter int FRAME_TO = 120000,
  parameter int CNT_W    = 18
) (
  input  logic       clk,
  input  logic       res,
  input  logic       enable,
  input  logic       vsync,
  output logic       stby,
  output logic       tg_en,
  output logic       blank,
  output logic       bl_en,
  output logic       ready,
  output logic       busy,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PWR_UP   = 3'd1,
    SYNC     = 3'd2,
    UNBLANK  = 3'd3,
    ON       = 3'd4,
    BL_OFF   = 3'd5,
    BLANK_DN = 3'd6,
    TG_OFF   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(FRAME_TO - 1);
  localparam logic [3:0]       SYNC_LAST = 4'(N_SYNC - 1);
  localparam logic [3:0]       BL_LAST   = 4'(N_BL - 1);
  localparam logic [3:0]       DOWN_LAST = 4'(N_DOWN - 1);

  state_t           st, nxt;
  logic [CNT_W-1:0] cyc;
  logic [3:0]       frm;
  logic             vsync_d;
  logic             fe, to, timed, set_err;

  assign fe    = vsync_d & ~vsync;
  // In states where the timing generator runs, cyc measures time since the last frame edge.
  assign timed = st inside {SYNC, UNBLANK, ON, BL_OFF, BLANK_DN};
  assign to    = (cyc == TO_LAST) && !fe;

  always_comb begin
    nxt     = st;
    set_err = 1'b0;
    case (st)
      OFF:      if (enable && !err) nxt = PWR_UP;
      PWR_UP:   if (!enable) nxt = OFF;
                else if (cyc == PWR_LAST) nxt = SYNC;
      SYNC:     if (!enable) nxt = TG_OFF;
                else if (to) begin nxt = TG_OFF; set_err = 1'b1; end
                else if (fe && frm == SYNC_LAST) nxt = UNBLANK;
      UNBLANK:  if (!enable) nxt = BLANK_DN;
                else if (to) begin nxt = BLANK_DN; set_err = 1'b1; end
                else if (fe && frm == BL_LAST) nxt = ON;
      ON:       if (!enable) nxt = BL_OFF;
                else if (to) begin nxt = BL_OFF; set_err = 1'b1; end
      BL_OFF:   if (fe) nxt = BLANK_DN;
                else if (to) begin nxt = BLANK_DN; set_err = 1'b1; end
      BLANK_DN: if (fe && frm == DOWN_LAST) nxt = TG_OFF;
                else if (to) begin nxt = TG_OFF; set_err = 1'b1; end
      TG_OFF:   if (cyc == OFF_LAST) nxt = OFF;
      default:  nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      st      <= OFF;
      cyc     <= '0;
      frm     <= '0;
      vsync_d <= 1'b0;
      err     <= 1'b0;
      stby    <= 1'b1;
      tg_en   <= 1'b0;
      blank   <= 1'b1;
      bl_en   <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      vsync_d <= vsync;
      st      <= nxt;
      // Transition clear wins, so an edge in the transition cycle is dropped.
      if (nxt != st) begin
        cyc <= '0;
        frm <= '0;
      end else begin
        cyc <= (timed && fe) ? '0 : cyc + 1'b1;
        frm <= frm + 4'(fe);
      end
      if (st == OFF && !enable) err <= 1'b0;
      else if (set_err)         err <= 1'b1;
      // Outputs decode the next state so they line up with the state register.
      stby  <= (nxt == OFF);
      tg_en <= nxt inside {SYNC, UNBLANK, ON, BL_OFF, BLANK_DN};
      blank <= nxt inside {OFF, PWR_UP, SYNC, BLANK_DN, TG_OFF};
      bl_en <= (nxt == ON);
      ready <= (nxt == ON);
      busy  <= !(nxt inside {OFF, ON});
    end
  end

  assign state = st;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench: expected state transitions are queued ahead of the stimulus and
// matched (state, dwell, frame edge, err, output decode) as the DUT moves.
module tb_lcd_power_seq;

  localparam logic [2:0] S_OFF = 3'd0, S_PWR = 3'd1, S_SYNC = 3'd2, S_UNB = 3'd3,
                         S_ON = 3'd4, S_BLO = 3'd5, S_BDN = 3'd6, S_TGO = 3'd7;

  logic clk = 1'b0;
  logic res, enable, vsync;
  logic stby, tg_en, blank, bl_en, ready, busy, err;
  logic [2:0] state;

  lcd_power_seq #(
    .T_PWR(8), .T_OFF(8), .N_SYNC(2), .N_BL(1), .N_DOWN(1), .FRAME_TO(100), .CNT_W(18)
  ) dut (
    .clk(clk), .res(res), .enable(enable), .vsync(vsync),
    .stby(stby), .tg_en(tg_en), .blank(blank), .bl_en(bl_en),
    .ready(ready), .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    int         dwell;
    bit         on_fe;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0, fails = 0;
  logic [2:0] cur_exp = S_OFF;
  int         dwell = 0;
  logic       vs_prev = 1'b0;
  int         ph = 0;
  bit         vs_run = 1'b1;

  // {stby, tg_en, blank, bl_en, ready, busy}
  function automatic logic [5:0] dec(input logic [2:0] s);
    case (s)
      S_OFF:   return 6'b101000;
      S_PWR:   return 6'b001001;
      S_SYNC:  return 6'b011001;
      S_UNB:   return 6'b010001;
      S_ON:    return 6'b010110;
      S_BLO:   return 6'b010001;
      S_BDN:   return 6'b011001;
      default: return 6'b001001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input int dw, input bit f, input logic e);
    exp_t x;
    x.st = s; x.dwell = dw; x.on_fe = f; x.err = e;
    sb.push_back(x);
  endtask

  task automatic monitor();
    logic fe_seen;
    exp_t e;
    fe_seen = vs_prev & ~vsync;
    vs_prev = res ? 1'b0 : vsync;
    if (state !== cur_exp) begin
      if (sb.size() == 0) begin
        chk("unexpected_transition", state, cur_exp);
        cur_exp = state;
      end else begin
        e = sb.pop_front();
        chk("tr_state", state, e.st);
        if (e.dwell >= 0) chk("tr_dwell", dwell, e.dwell);
        if (e.on_fe) chk("tr_on_fe", fe_seen, 1);
        chk("tr_err", err, e.err);
        cur_exp = e.st;
      end
      dwell = 1;
    end else begin
      dwell++;
    end
    chk("outputs", {stby, tg_en, blank, bl_en, ready, busy}, dec(cur_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1 monitor();
    @(negedge clk);
    ph    = (ph == 39) ? 0 : ph + 1;
    vsync = vs_run ? (ph >= 3) : 1'b1;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    res = 1'b1; enable = 1'b1; vsync = 1'b1;
    // Reset held with enable high.
    repeat (3) tick();
    chk("rst_state", state, S_OFF);
    chk("rst_outs", {stby, tg_en, blank, bl_en, ready, busy, err}, 7'b1010000);
    push(S_PWR, -1, 0, 0); push(S_SYNC, 8, 0, 0);
    push(S_UNB, -1, 1, 0); push(S_ON, 40, 1, 0);
    res = 1'b0;
    wait_done(300, "powerup");
    repeat (5) tick();
    chk("on_ready", {ready, busy, bl_en}, 3'b101);

    // Normal power-down.
    push(S_BLO, -1, 0, 0); push(S_BDN, -1, 1, 0);
    push(S_TGO, 40, 1, 0); push(S_OFF, 8, 0, 0);
    enable = 1'b0;
    wait_done(300, "powerdown");
    chk("down_err", err, 0);

    // Abort in PWR_UP at cyc=3.
    push(S_PWR, -1, 0, 0); push(S_OFF, 4, 0, 0);
    tick(); enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    wait_done(20, "abort_pwr");
    chk("abort_pwr_tg", tg_en, 0);

    // Abort in SYNC goes straight to TG_OFF.
    push(S_PWR, -1, 0, 0); push(S_SYNC, 8, 0, 0);
    push(S_TGO, -1, 0, 0); push(S_OFF, 8, 0, 0);
    enable = 1'b1;
    repeat (12) tick();
    enable = 1'b0;
    wait_done(50, "abort_sync");

    // Frame timeout while ON, then recovery.
    push(S_PWR, -1, 0, 0); push(S_SYNC, 8, 0, 0);
    push(S_UNB, -1, 1, 0); push(S_ON, 40, 1, 0);
    enable = 1'b1;
    wait_done(300, "powerup2");
    vs_run = 1'b0;
    push(S_BLO, 100, 0, 1); push(S_BDN, 100, 0, 1);
    push(S_TGO, 100, 0, 1); push(S_OFF, 8, 0, 1);
    wait_done(600, "timeout_seq");
    repeat (20) tick();
    chk("err_hold_state", state, S_OFF);
    chk("err_sticky", err, 1);
    enable = 1'b0;
    tick();
    chk("err_clear", err, 0);
    push(S_PWR, -1, 0, 0);
    enable = 1'b1;
    wait_done(10, "restart");
    vs_run = 1'b1;

    // Enable re-raised during BLANK_DN is ignored until OFF.
    push(S_SYNC, 8, 0, 0); push(S_UNB, -1, 1, 0); push(S_ON, 40, 1, 0);
    wait_done(300, "powerup3");
    push(S_BLO, -1, 0, 0); push(S_BDN, -1, 1, 0);
    enable = 1'b0;
    wait_done(100, "to_blank_dn");
    push(S_TGO, 40, 1, 0); push(S_OFF, 8, 0, 0); push(S_PWR, 1, 0, 0);
    repeat (5) tick();
    enable = 1'b1;
    wait_done(200, "ignore_enable");

    // Reset mid-sequence in UNBLANK.
    push(S_SYNC, 8, 0, 0); push(S_UNB, -1, 1, 0);
    wait_done(300, "to_unblank");
    push(S_OFF, -1, 0, 0);
    res = 1'b1; enable = 1'b0;
    tick();
    chk("midrst_state", state, S_OFF);
    chk("midrst_outs", {stby, tg_en, blank, bl_en, ready, busy, err}, 7'b1010000);
    res = 1'b0;
    repeat (3) tick();

    // Frame edge coincident with SYNC entry must not count toward N_SYNC.
    push(S_PWR, -1, 0, 0); push(S_SYNC, 8, 1, 0);
    push(S_UNB, 80, 1, 0); push(S_ON, 40, 1, 0);
    ph = 31;
    tick();
    enable = 1'b1;
    wait_done(300, "edge_align");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
